// File: rtl/lut8_bank_pkg.sv
// Shared definitions for the gated 8-bit register bank controllers:
// FSM state encoding, pulse counter width and an index-width helper.
package lut8_bank_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    ACK   = 3'd2,
    SET   = 3'd3,
    CLR   = 3'd4
  } state_t;

  localparam int PULSE_CNT_W = 4;

  // Width of an index into n items; never less than one bit so ports stay legal.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lut8_bank_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping at N_REQ. valid is low when no request is asserted.
module rr_pick
  import lut8_bank_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [idx_w(N_REQ)-1:0] ptr,
  output logic [idx_w(N_REQ)-1:0] grant,
  output logic                    valid
);

  localparam int IW = idx_w(N_REQ);
  localparam int SW = IW + 1;

  logic [SW-1:0] sum;
  logic [IW-1:0] idx;

  // One extra bit on the sum keeps the wrap compare exact for any N_REQ.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int off = 0; off < N_REQ; off++) begin
      sum = {1'b0, ptr} + SW'(off);
      if (sum >= SW'(N_REQ)) begin
        sum = sum - SW'(N_REQ);
      end
      idx = sum[IW-1:0];
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/lut8_bank_wr_arbiter.sv
// Write arbiter and set/clear pulse sequencer for a shared gated register bank.
// Every output is a flop, so the bank sees glitch-free strobes.
module lut8_bank_wr_arbiter
  import lut8_bank_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int W         = 8,
  parameter int PULSE_CYC = 2
) (
  input  logic                    C,
  input  logic                    R,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*W-1:0]      wdata,
  input  logic                    preset_req,
  input  logic                    clear_req,
  output logic [N_REQ-1:0]        ack,
  output logic [W-1:0]            bank_d,
  output logic                    bank_sel,
  output logic                    bank_e,
  output logic                    bank_s,
  output logic                    bank_r,
  output logic                    busy,
  output logic [idx_w(N_REQ)-1:0] last_gnt
);

  localparam int IW = idx_w(N_REQ);
  localparam logic [PULSE_CNT_W-1:0] PULSE_LOAD = PULSE_CNT_W'(PULSE_CYC - 1);

  state_t state_q, state_n;
  logic [IW-1:0]          gnt_q, gnt_n;
  logic [IW-1:0]          ptr_q, ptr_n;
  logic [PULSE_CNT_W-1:0] cnt_q, cnt_n;

  logic [N_REQ-1:0] ack_n;
  logic [W-1:0]     bank_d_n;
  logic             bank_sel_n, bank_e_n, bank_s_n, bank_r_n, busy_n;
  logic [IW-1:0]    last_gnt_n;

  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic [W-1:0]  slice [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign slice[i] = wdata[i*W +: W];
  end

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_rr_pick (
    .req  (req),
    .ptr  (ptr_q),
    .grant(pick_idx),
    .valid(pick_valid)
  );

  // Next state plus the output values for the cycle after the edge; the
  // strobes are decided here and registered, never decoded from state.
  always_comb begin
    state_n    = state_q;
    gnt_n      = gnt_q;
    ptr_n      = ptr_q;
    cnt_n      = cnt_q;
    ack_n      = '0;
    bank_d_n   = '0;
    bank_sel_n = 1'b0;
    bank_e_n   = 1'b0;
    bank_s_n   = 1'b0;
    bank_r_n   = 1'b0;
    last_gnt_n = last_gnt;

    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_n  = CLR;
          cnt_n    = PULSE_LOAD;
          bank_r_n = 1'b1;
        end else if (preset_req) begin
          state_n  = SET;
          cnt_n    = PULSE_LOAD;
          bank_s_n = 1'b1;
        end else if (pick_valid) begin
          state_n    = WRITE;
          gnt_n      = pick_idx;
          last_gnt_n = pick_idx;
          bank_e_n   = 1'b1;
          bank_sel_n = 1'b1;
          bank_d_n   = slice[pick_idx];
        end
      end
      WRITE: begin
        state_n       = ACK;
        ack_n[gnt_q]  = 1'b1;
      end
      ACK: begin
        state_n = IDLE;
        ptr_n   = (gnt_q == IW'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
      end
      SET: begin
        if (cnt_q == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n    = cnt_q - 1'b1;
          bank_s_n = 1'b1;
        end
      end
      CLR: begin
        if (cnt_q == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n    = cnt_q - 1'b1;
          bank_r_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // Reset truncates any pulse in flight and drops a pending acknowledge.
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      ack      <= '0;
      bank_d   <= '0;
      bank_sel <= 1'b0;
      bank_e   <= 1'b0;
      bank_s   <= 1'b0;
      bank_r   <= 1'b0;
      busy     <= 1'b0;
      last_gnt <= '0;
    end else begin
      state_q  <= state_n;
      gnt_q    <= gnt_n;
      ptr_q    <= ptr_n;
      cnt_q    <= cnt_n;
      ack      <= ack_n;
      bank_d   <= bank_d_n;
      bank_sel <= bank_sel_n;
      bank_e   <= bank_e_n;
      bank_s   <= bank_s_n;
      bank_r   <= bank_r_n;
      busy     <= busy_n;
      last_gnt <= last_gnt_n;
    end
  end

endmodule

// File: tb/tb_lut8_bank_wr_arbiter.sv
// Bench for lut8_bank_wr_arbiter: table vectors, directed corner sequences
// and random traffic against a transaction-level schedule model.
module tb_lut8_bank_wr_arbiter;

  localparam int N_REQ     = 4;
  localparam int W         = 8;
  localparam int PULSE_CYC = 2;
  localparam int IW        = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] wdata;
  logic               preset_req, clear_req;
  logic [N_REQ-1:0]   ack;
  logic [W-1:0]       bank_d;
  logic               bank_sel, bank_e, bank_s, bank_r, busy;
  logic [IW-1:0]      last_gnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [N_REQ-1:0] ack;
    logic [W-1:0]     bank_d;
    logic             bank_sel;
    logic             bank_e;
    logic             bank_s;
    logic             bank_r;
    logic             busy;
    logic [IW-1:0]    last_gnt;
  } obs_t;

  typedef struct {
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] wdata;
    logic               preset_req;
    logic               clear_req;
    obs_t               expv;
  } vec_t;

  always #5 clk = ~clk;

  lut8_bank_wr_arbiter #(
    .N_REQ(N_REQ), .W(W), .PULSE_CYC(PULSE_CYC)
  ) dut (
    .C(clk), .R(rst), .req(req), .wdata(wdata),
    .preset_req(preset_req), .clear_req(clear_req),
    .ack(ack), .bank_d(bank_d), .bank_sel(bank_sel), .bank_e(bank_e),
    .bank_s(bank_s), .bank_r(bank_r), .busy(busy), .last_gnt(last_gnt)
  );

  function automatic obs_t observe();
    obs_t o;
    o.ack = ack; o.bank_d = bank_d; o.bank_sel = bank_sel; o.bank_e = bank_e;
    o.bank_s = bank_s; o.bank_r = bank_r; o.busy = busy; o.last_gnt = last_gnt;
    return o;
  endfunction

  function automatic obs_t mk(input logic [N_REQ-1:0] a, input logic [W-1:0] d,
                              input logic sel, input logic e, input logic s,
                              input logic r, input logic b, input logic [IW-1:0] lg);
    obs_t o;
    o.ack = a; o.bank_d = d; o.bank_sel = sel; o.bank_e = e;
    o.bank_s = s; o.bank_r = r; o.busy = b; o.last_gnt = lg;
    return o;
  endfunction

  // Reference model: each decision schedules the whole transaction's output
  // cycles at once, followed by the one idle cycle before the next decision.
  obs_t        exp_q[$];
  obs_t        m_cur;
  int          m_ptr;
  logic [IW-1:0] m_last;

  function automatic obs_t idle_rec();
    return mk('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m_last);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ptr  = 0;
    m_last = '0;
    m_cur  = idle_rec();
  endtask

  task automatic model_step();
    obs_t rec;
    int g;
    if (rst) begin
      model_reset();
      return;
    end
    if (exp_q.size() == 0) begin
      if (clear_req || preset_req) begin
        for (int k = 0; k < PULSE_CYC; k++) begin
          rec = idle_rec();
          rec.busy = 1'b1;
          if (clear_req) rec.bank_r = 1'b1;
          else rec.bank_s = 1'b1;
          exp_q.push_back(rec);
        end
        exp_q.push_back(idle_rec());
      end else if (req != '0) begin
        g = -1;
        for (int k = 0; k < N_REQ; k++) begin
          if (g < 0 && req[(m_ptr + k) % N_REQ]) g = (m_ptr + k) % N_REQ;
        end
        m_last = IW'(g);
        m_ptr  = (g + 1) % N_REQ;
        rec = idle_rec();
        rec.bank_e = 1'b1; rec.bank_sel = 1'b1; rec.busy = 1'b1;
        rec.bank_d = wdata[g*W +: W];
        exp_q.push_back(rec);
        rec = idle_rec();
        rec.ack[g] = 1'b1; rec.busy = 1'b1;
        exp_q.push_back(rec);
        exp_q.push_back(idle_rec());
      end
    end
    if (exp_q.size() != 0) m_cur = exp_q.pop_front();
    else m_cur = idle_rec();
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic [N_REQ*W-1:0] d,
                               input logic p, input logic c);
    req = r; wdata = d; preset_req = p; clear_req = c;
  endtask

  task automatic checkOutput(input string name, input obs_t expv);
    obs_t act;
    act = observe();
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic check_val(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // One clock: model samples the same inputs as the DUT, outputs checked at negedge.
  task automatic tick(input string name);
    @(posedge clk);
    model_step();
    @(negedge clk);
    checkOutput(name, m_cur);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus('0, '0, 1'b0, 1'b0);
    model_reset();
    tick("reset_hold");
    rst = 1'b0;
  endtask

  vec_t tbl[10];

  initial begin : main
    int cyc, n_ack, last_ack_cyc, n_wr, ack_cyc;
    logic [W-1:0] exp_d [5];
    int           exp_g [5];

    rst = 1'b1;
    applyStimulus('0, '0, 1'b0, 1'b0);
    model_reset();
    #2;
    checkOutput("reset_state", mk('0, '0, 0, 0, 0, 0, 0, '0));
    tick("reset_hold");
    rst = 1'b0;

    // Single write of slice0, then a preset pulse and a clear pulse.
    tbl[0] = '{4'b0001, 32'h000000A5, 0, 0, mk(4'b0000, 8'hA5, 1, 1, 0, 0, 1, 2'd0)};
    tbl[1] = '{4'b0001, 32'h000000A5, 0, 0, mk(4'b0001, 8'h00, 0, 0, 0, 0, 1, 2'd0)};
    tbl[2] = '{4'b0000, 32'h000000A5, 0, 0, mk(4'b0000, 8'h00, 0, 0, 0, 0, 0, 2'd0)};
    tbl[3] = '{4'b0000, 32'h000000A5, 0, 0, mk(4'b0000, 8'h00, 0, 0, 0, 0, 0, 2'd0)};
    tbl[4] = '{4'b0000, 32'h12345678, 1, 0, mk(4'b0000, 8'h00, 0, 0, 1, 0, 1, 2'd0)};
    tbl[5] = '{4'b0000, 32'h12345678, 0, 0, mk(4'b0000, 8'h00, 0, 0, 1, 0, 1, 2'd0)};
    tbl[6] = '{4'b0000, 32'h12345678, 0, 0, mk(4'b0000, 8'h00, 0, 0, 0, 0, 0, 2'd0)};
    tbl[7] = '{4'b0000, 32'h12345678, 0, 1, mk(4'b0000, 8'h00, 0, 0, 0, 1, 1, 2'd0)};
    tbl[8] = '{4'b0000, 32'h12345678, 0, 0, mk(4'b0000, 8'h00, 0, 0, 0, 1, 1, 2'd0)};
    tbl[9] = '{4'b0000, 32'h12345678, 0, 0, mk(4'b0000, 8'h00, 0, 0, 0, 0, 0, 2'd0)};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].req, tbl[i].wdata, tbl[i].preset_req, tbl[i].clear_req);
      tick("tbl_model");
      checkOutput($sformatf("tbl[%0d]", i), tbl[i].expv);
    end

    // All four requesters held: round-robin order and 3-cycle ack spacing.
    do_reset();
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    exp_g = '{0, 1, 2, 3, 0};
    applyStimulus(4'b1111, 32'h44332211, 1'b0, 1'b0);
    n_ack = 0; n_wr = 0; last_ack_cyc = 0; cyc = 0;
    while (n_ack < 5 && cyc < 40) begin
      cyc++;
      tick("rr_model");
      if (bank_e && n_wr < 5) begin
        check_val($sformatf("rr_bank_d[%0d]", n_wr), bank_d, exp_d[n_wr]);
        n_wr++;
      end
      if (ack != '0) begin
        check_val($sformatf("rr_ack[%0d]", n_ack), ack, 1 << exp_g[n_ack]);
        check_val($sformatf("rr_last_gnt[%0d]", n_ack), last_gnt, exp_g[n_ack]);
        if (n_ack > 0) check_val("rr_ack_spacing", cyc - last_ack_cyc, 3);
        last_ack_cyc = cyc;
        n_ack++;
      end
    end
    check_val("rr_ack_count", n_ack, 5);
    applyStimulus('0, 32'h44332211, 1'b0, 1'b0);
    tick("rr_drain");
    tick("rr_drain");

    // Clear, preset and a write all pending: served in priority order.
    do_reset();
    applyStimulus(4'b0100, 32'h005C0000, 1'b1, 1'b1);
    cyc = 0; ack_cyc = -1;
    while (ack_cyc < 0 && cyc < 40) begin
      cyc++;
      tick("prio_model");
      if (bank_r) clear_req = 1'b0;
      if (bank_s) begin
        preset_req = 1'b0;
        check_val("prio_clear_done_first", clear_req, 0);
      end
      if (bank_e) check_val("prio_bank_d", bank_d, 8'h5C);
      if (ack != '0) begin
        ack_cyc = cyc;
        check_val("prio_ack", ack, 4'b0100);
        req = '0;
      end
    end
    check_val("prio_ack_cycle", ack_cyc, 2 * PULSE_CYC + 4);
    tick("prio_drain");

    // Reset in the middle of a preset pulse, then a pending write from requester 1.
    do_reset();
    applyStimulus(4'b0010, 32'h00007E00, 1'b1, 1'b0);
    tick("rst_set1");
    preset_req = 1'b0;
    tick("rst_set2");
    check_val("rst_bank_s_before", bank_s, 1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    checkOutput("rst_async_drop", mk('0, '0, 0, 0, 0, 0, 0, '0));
    tick("rst_hold");
    rst = 1'b0;
    tick("rst_write");
    check_val("rst_grant", last_gnt, 1);
    check_val("rst_bank_d", bank_d, 8'h7E);
    tick("rst_ack");
    check_val("rst_ack", ack, 4'b0010);
    req = '0;
    tick("rst_drain");

    // Pointer wraps from requester 3 back to 0.
    do_reset();
    applyStimulus(4'b1000, 32'h3300000F, 1'b0, 1'b0);
    tick("wrap_write3");
    check_val("wrap_grant3", last_gnt, 3);
    tick("wrap_ack3");
    check_val("wrap_ack3", ack, 4'b1000);
    req = 4'b1001;
    tick("wrap_idle");
    tick("wrap_write0");
    check_val("wrap_grant0", last_gnt, 0);
    check_val("wrap_bank_d0", bank_d, 8'h0F);
    req = '0;
    tick("wrap_ack0");
    tick("wrap_drain");

    // Random traffic with occasional resets, checked cycle by cycle.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        checkOutput("rand_rst", mk('0, '0, 0, 0, 0, 0, 0, '0));
        tick("rand_rst_hold");
        rst = 1'b0;
      end
      applyStimulus(N_REQ'($urandom), $urandom,
                    ($urandom_range(0, 11) == 0), ($urandom_range(0, 13) == 0));
      tick("rand");
      if (bank_s && bank_r) check_val("rand_s_r_overlap", 1, 0);
      if ((bank_s || bank_r) && bank_e) check_val("rand_pulse_during_e", 1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
